program_loader: RTL

- Write-side counterpart of the instruction ROM. Receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them sequentially into the writable program memory, starting at the MIPS text base address.
- Holds the CPU in reset while loading.
- Validates the image with a header word count and a trailing XOR checksum.

---
 rtl/program_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: header word count, big-endian word assembly, XOR checksum.
// A word is written one cycle after its 4th byte; byte_ready stays high through writes, so 1 byte/cycle is sustained.
module program_loader #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          MEMORY_DEPTH = 'h200,
  parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000,
  parameter int          CNT_WIDTH    = $clog2(MEMORY_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [CNT_WIDTH-1:0]  words_loaded
);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    LOAD,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam logic [DATA_WIDTH-1:0] DEPTH_WORD = DATA_WIDTH'(MEMORY_DEPTH);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);

  state_t                 state;
  logic [1:0]             byte_count;
  logic [DATA_WIDTH-9:0]  shift;
  logic [7:0]             checksum;
  logic [CNT_WIDTH-1:0]   word_count;

  logic                   fire;
  logic                   last_byte;
  logic [DATA_WIDTH-1:0]  next_word;
  logic [DATA_WIDTH-1:0]  word_offset;

  always_comb begin
    fire       = byte_valid && byte_ready;
    last_byte  = (byte_count == 2'd3);
    next_word  = {shift, byte_in};
    // Byte offset of the word being written: 4 * words_loaded, zero-extended.
    word_offset = '0;
    word_offset[CNT_WIDTH+1:2] = words_loaded;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      byte_count     <= 2'd0;
      shift          <= '0;
      checksum       <= 8'h00;
      word_count     <= '0;
      byte_ready     <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= BASE_ADDRESS;
      mem_write_data <= '0;
      cpu_hold       <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      words_loaded   <= '0;
    end else begin
      mem_write <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state        <= HEADER;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            byte_count   <= 2'd0;
            checksum     <= 8'h00;
            shift        <= '0;
            cpu_hold     <= 1'b1;
            byte_ready   <= 1'b1;
          end
        end

        HEADER: begin
          if (fire) begin
            shift      <= next_word[DATA_WIDTH-9:0];
            byte_count <= 2'(byte_count + 2'd1);
            if (last_byte) begin
              if (next_word == '0) begin
                state <= CHECK;
              end else if (next_word > DEPTH_WORD) begin
                state      <= ERROR;
                error      <= 1'b1;
                cpu_hold   <= 1'b0;
                byte_ready <= 1'b0;
              end else begin
                state      <= LOAD;
                word_count <= next_word[CNT_WIDTH-1:0];
              end
            end
          end
        end

        LOAD: begin
          if (fire) begin
            shift      <= next_word[DATA_WIDTH-9:0];
            checksum   <= checksum ^ byte_in;
            byte_count <= 2'(byte_count + 2'd1);
            if (last_byte) begin
              mem_write      <= 1'b1;
              mem_write_data <= next_word;
              mem_address    <= BASE_ADDRESS + word_offset;
              words_loaded   <= words_loaded + CNT_ONE;
              if (words_loaded + CNT_ONE == word_count) begin
                state <= CHECK;
              end
            end
          end
        end

        CHECK: begin
          if (fire) begin
            if (byte_in == checksum) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
            cpu_hold   <= 1'b0;
            byte_ready <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
